// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - Execute-stage to multiply/divide unit signal bundle
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        cancel;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;

  modport master (
    output start, op, rs, rt, cancel,
    input  HI, LO, busy
  );

  modport slave (
    input  start, op, rs, rt, cancel,
    output HI, LO, busy
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - fixed-latency multiply/divide unit owning architectural HI/LO
module md_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [63:0]    res_q, res_d;
  logic           pend_q, pend_d;

  logic           accept;
  logic [63:0]    prod_s, prod_u;
  logic           div_zero;
  logic [31:0]    divisor;
  logic           a_neg, b_neg;
  logic [31:0]    a_mag, b_mag;
  logic [31:0]    mag_q, mag_r;
  logic [31:0]    sdiv_q, sdiv_r;
  logic [31:0]    udiv_q, udiv_r;

  // A start only counts when idle, not flushed, and carrying a real op code.
  assign accept = md.start && !md.cancel && (state_q == S_IDLE) &&
                  (md.op != 3'd0) && (md.op != 3'd7);

  // Result datapath. Signed division is done on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 naturally, and a zero divisor is
  // replaced by 1 so the dividers never see zero (that result is discarded).
  always_comb begin
    prod_s   = $signed({{32{md.rs[31]}}, md.rs}) * $signed({{32{md.rt[31]}}, md.rt});
    prod_u   = {32'd0, md.rs} * {32'd0, md.rt};
    div_zero = (md.rt == 32'd0);
    divisor  = div_zero ? 32'd1 : md.rt;
    a_neg    = md.rs[31];
    b_neg    = divisor[31];
    a_mag    = a_neg ? (32'd0 - md.rs) : md.rs;
    b_mag    = b_neg ? (32'd0 - divisor) : divisor;
    mag_q    = a_mag / b_mag;
    mag_r    = a_mag % b_mag;
    sdiv_q   = (a_neg ^ b_neg) ? (32'd0 - mag_q) : mag_q;
    sdiv_r   = a_neg ? (32'd0 - mag_r) : mag_r;
    udiv_q   = md.rs / divisor;
    udiv_r   = md.rs % divisor;
  end

  // Next-state: accept/launch in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (md.op)
            OP_MULT: begin
              res_d   = prod_s;
              pend_d  = 1'b1;
              cnt_d   = MUL_LOAD;
              state_d = S_RUN;
            end
            OP_MULTU: begin
              res_d   = prod_u;
              pend_d  = 1'b1;
              cnt_d   = MUL_LOAD;
              state_d = S_RUN;
            end
            OP_DIV: begin
              res_d   = {sdiv_r, sdiv_q};
              pend_d  = !div_zero;
              cnt_d   = DIV_LOAD;
              state_d = S_RUN;
            end
            OP_DIVU: begin
              res_d   = {udiv_r, udiv_q};
              pend_d  = !div_zero;
              cnt_d   = DIV_LOAD;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = md.rs;
            OP_MTLO: lo_d = md.rs;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
          if (pend_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and architectural register update; reset abandons any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      res_q   <= 64'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      pend_q  <= pend_d;
    end
  end

  assign md.HI   = hi_q;
  assign md.LO   = lo_q;
  assign md.busy = (state_q == S_RUN);

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit against a behavioural model
module tb_md_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic clk;
  logic reset;

  md_unit_if md ();

  md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  typedef struct {
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb2, q, r;
    longint xs, ys;
    longint unsigned xu, yu;
    int unsigned ua, ub;
    sa = a; sb2 = b; ua = a; ub = b;
    case (o)
      3'd1: begin xs = sa; ys = sb2; return xs * ys; end
      3'd2: begin xu = ua; yu = ub; return xu * yu; end
      3'd3: begin
        if (sa == int'(32'h80000000) && sb2 == -1) begin
          q = sa; r = 0;
        end else begin
          q = sa / sb2; r = sa % sb2;
        end
        return {r, q};
      end
      3'd4: return {ua % ub, ua / ub};
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: counts busy cycles, checks HI/LO hold during RUN, and on each
  // completion (busy falling) pops and compares the expected result.
  initial begin
    logic prev;
    int   bcnt;
    exp_t e;
    prev = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        bcnt = 0;
      end else if (md.busy) begin
        bcnt++;
        chk("busy_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          chk("hold_hi", md.HI, exp_q[0].old_hi);
          chk("hold_lo", md.LO, exp_q[0].old_lo);
        end
        prev = 1'b1;
      end else begin
        if (prev) begin
          chk("completion_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("busy_len", bcnt, e.n);
            chk("res_hi", md.HI, e.hi);
            chk("res_lo", md.LO, e.lo);
          end
        end
        prev = 1'b0;
        bcnt = 0;
      end
    end
  end

  // Drive one start cycle; called just after a rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
    logic        acc;
    logic [63:0] r;
    exp_t        e;
    acc = !c && (o != 3'd0) && (o != 3'd7) && (exp_q.size() == 0);
    if (!c && (o != 3'd0) && (o != 3'd7) && (exp_q.size() != 0))
      $display("note: protocol violation, start op=%0d while busy; unit must ignore it", o);
    if (acc && o <= 3'd4) begin
      e.n      = (o <= 3'd2) ? MUL_N : DIV_N;
      e.old_hi = m_hi;
      e.old_lo = m_lo;
      if (o >= 3'd3 && b == 32'd0) r = {m_hi, m_lo};
      else r = ref_md(o, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
      exp_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end else if (acc && o == 3'd5) begin
      m_hi = a;
    end else if (acc && o == 3'd6) begin
      m_lo = a;
    end
    md.start = 1'b1; md.op = o; md.rs = a; md.rt = b; md.cancel = c;
    @(posedge clk);
    #1;
    md.start = 1'b0; md.op = 3'd0; md.cancel = 1'b0;
    if (exp_q.size() == 0) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, md.busy}, 32'd0);
      chk("idle_hi", md.HI, m_hi);
      chk("idle_lo", md.LO, m_lo);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    logic        c;
    md.start = 1'b0; md.op = 3'd0; md.rs = 32'd0; md.rt = 32'd0; md.cancel = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, md.busy}, 32'd0);
    chk("rst_hi", md.HI, 32'd0);
    chk("rst_lo", md.LO, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0); wait_idle();
    chk("mult_hi", md.HI, 32'hFFFFFFFF);
    chk("mult_lo", md.LO, 32'hFFFFFFFA);
    issue(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0); wait_idle();
    chk("multu_hi", md.HI, 32'h00000002);
    chk("multu_lo", md.LO, 32'hFFFFFFFA);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0); wait_idle();
    chk("div_hi", md.HI, 32'hFFFFFFFF);
    chk("div_lo", md.LO, 32'hFFFFFFFD);
    issue(3'd4, 32'd7, 32'd2, 1'b0); wait_idle();
    chk("divu_hi", md.HI, 32'd1);
    chk("divu_lo", md.LO, 32'd3);

    issue(3'd5, 32'h11, 32'd0, 1'b0);
    issue(3'd6, 32'h22, 32'd0, 1'b0);
    issue(3'd3, 32'h1234, 32'd0, 1'b0); wait_idle();
    chk("div0_hi", md.HI, 32'h11);
    chk("div0_lo", md.LO, 32'h22);

    issue(3'd1, 32'd9, 32'd9, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("cancel_hi", md.HI, 32'h11);

    issue(3'd4, 32'd100, 32'd7, 1'b0);
    @(posedge clk); #1 md.cancel = 1'b1;
    @(posedge clk); #1 md.cancel = 1'b0;
    wait_idle();
    chk("divu_cancel_hi", md.HI, 32'd2);
    chk("divu_cancel_lo", md.LO, 32'd14);

    issue(3'd1, 32'h12345, 32'h777, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, md.busy}, 32'd0);
    chk("async_rst_hi", md.HI, 32'd0);
    chk("async_rst_lo", md.LO, 32'd0);
    exp_q.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_busy", {31'd0, md.busy}, 32'd0);
    chk("post_rst_hi", md.HI, 32'd0);
    chk("post_rst_lo", md.LO, 32'd0);
    @(posedge clk); #1;

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    @(posedge clk); #1;
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_idle();
    chk("ovf_hi", md.HI, 32'd0);
    chk("ovf_lo", md.LO, 32'h80000000);

    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      c = ($urandom_range(0, 7) == 0);
      issue(o, a, b, c);
      wait_idle();
    end

    chk("final_hi", md.HI, m_hi);
    chk("final_lo", md.LO, m_lo);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit, instantiated inside the Execute stage.
- Receives operands and an op code from E, computes a 64-bit product or a quotient/remainder over a fixed latency, and owns the architectural HI/LO registers.
- Supplies HI/LO to E for MFHI/MFLO, and drives `busy` for the hazard logic that stalls MD instructions in D.
- `cancel` is driven from E's `stop` (exception/interrupt flush).

Parameters:
MUL_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  E holds a valid MD instruction this cycle
op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 reserved
rs  input  32  operand A / MT source
rt  input  32  operand B
cancel  input  1  flush; kills a start in the same cycle
HI  output  32  architectural HI
LO  output  32  architectural LO
busy  output  1  operation in flight

Behaviour:
- Reset (async, any cycle):
  - HI=0, LO=0, busy=0, counter=0, pending result cleared.
  - An in-flight operation is abandoned.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- Accepted start: start=1 and cancel=0 and state IDLE and op in 1..6. All other cases (op=0 or 7, cancel=1, or RUN) are ignored with no state change.
- MULT/MULTU/DIV/DIVU accepted at edge T:
  - Latch the result internally.
  - RUN begins; busy=1 from T+1.
  - Counter loads N-1 (N = MUL_CYCLES or DIV_CYCLES) and decrements each cycle in RUN.
  - On the edge where counter==0: HI/LO commit, busy falls. Net effect: busy high for exactly N cycles and new HI/LO visible from cycle T+N+1.
  - HI/LO hold their old values throughout RUN.
- MULT: signed 32x32 to 64; HI = bits[63:32], LO = bits[31:0]. MULTU: unsigned.
- DIV:
  - Signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- DIVU: unsigned.
- Divide by zero (rt==0): the full DIV_CYCLES busy period runs, then HI/LO stay unchanged.
- MTHI/MTLO accepted at T: HI (or LO) = rs, visible from T+1. busy never asserts.
- cancel:
  - Suppresses only a start in the same cycle.
  - An operation already in RUN always completes and commits; it belongs to an older, committed instruction.
- Upstream contract: hazard logic stalls MD/MF/MT instructions in D while (start|busy). A start arriving during RUN is a protocol violation; the unit ignores it and the bench flags it.
- HI/LO outputs are plain register outputs with no bypass. E reads them combinationally for MFHI/MFLO.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE, rt=3 at T -> busy=1 for cycles T+1..T+5; from T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy for exactly 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO (each visible next cycle, busy stays 0); then DIV with rt=0 -> busy for 10 cycles, HI=0x11 and LO=0x22 unchanged.
- start=1 op=MULT with cancel=1 -> busy stays 0, HI/LO unchanged. Separately, cancel pulsed at cycle 3 of an in-flight DIVU -> the result still commits on schedule.
- Assert reset asynchronously mid-RUN (between clock edges) -> busy, HI, LO read 0 immediately; no commit after reset releases.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. A second start issued while busy is ignored and the first result is intact.
